// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults and index-width helper for the round-robin mux
package mux_pkg;
  localparam int MUX_WIDTH_DEF = 8;
  localparam int MUX_N_DEF = 4;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_rr_n_arbiter.sv
// rr_arbiter: combinational grant starting at ptr, wrapping at N
// MUX_RR_FIXED_PRIO_EN switches to fixed priority (lowest index wins, ptr ignored)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = MUX_N_DEF,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);
`ifdef MUX_RR_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif
  logic [SELW-1:0] idx;
  always_comb begin
    idx = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // scan from the far end so the nearest valid candidate is written last
    for (int k = N - 1; k >= 0; k--) begin
`ifdef MUX_RR_FIXED_PRIO_EN
      idx = SELW'(k);
`else
      idx = SELW'((int'(ptr) + k) % N);
`endif
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
    gnt_onehot = gnt_any ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel registered mux with valid/ready and round-robin selection
// MUX_RR_FIXED_PRIO_EN replaces round-robin with fixed priority and drops the pointer
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF,
  parameter int N = MUX_N_DEF,
  localparam int SELW = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  arb_ptr, gnt_idx;
  logic [N-1:0]     gnt_onehot;
  logic             gnt_any, can_load, load;
  rr_arbiter #(.N(N)) u_arb (
    .req        (in_valid),
    .ptr        (arb_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );
`ifdef MUX_RR_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [SELW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
  always_comb ptr_d = load ? ((gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
`endif
  always_comb begin
    can_load = !out_valid_q || out_ready;
    load = can_load && gnt_any;
    in_ready = (rst_n && can_load) ? gnt_onehot : '0;
    out_valid_d = load || (out_valid_q && !out_ready);
    out_sel_d = load ? gnt_idx : out_sel_q;
    out_data_d = out_data_q;
    for (int i = 0; i < N; i++)
      if (load && gnt_onehot[i]) out_data_d = in_data[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
    end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: random and directed checks of mux_rr_n (N=4 and N=3) against a scan-order model
module tb_mux_rr_n;
`ifdef MUX_RR_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] in_data_a;
  logic [3:0]  in_valid_a, in_ready_a;
  logic [7:0]  out_data_a;
  logic        out_valid_a, out_ready_a;
  logic [1:0]  out_sel_a;
  logic [23:0] in_data_b;
  logic [2:0]  in_valid_b, in_ready_b;
  logic [7:0]  out_data_b;
  logic        out_valid_b, out_ready_b;
  logic [1:0]  out_sel_b;
  int n_cmp = 0, n_bad = 0;
  int mp[2], ms[2], np[2], ns[2];
  logic mv[2], nv[2];
  logic [7:0] md[2], nd[2];

  mux_rr_n #(.WIDTH(8), .N(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_sel(out_sel_a)
  );
  mux_rr_n #(.WIDTH(8), .N(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sel(out_sel_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int n, input logic [3:0] v, input int p);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = FIXED ? k : (p + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; md[d] = 8'h00; ms[d] = 0; mp[d] = 0;
    end
  endtask

  task automatic model(input int d, input int n, input logic [3:0] v, input logic [31:0] data,
                       input logic ordy, input logic [3:0] rdy, input logic ov,
                       input logic [7:0] od, input logic [1:0] os);
    string t;
    int g;
    logic can;
    t = d ? "n3" : "n4";
    g = pick(n, v, mp[d]);
    can = !mv[d] || ordy;
    check({t, "_in_ready"}, rdy, (can && g >= 0) ? (32'd1 << g) : 32'd0);
    check({t, "_out_valid"}, ov, mv[d]);
    check({t, "_out_data"}, od, md[d]);
    check({t, "_out_sel"}, os, ms[d]);
    nv[d] = mv[d] && !ordy; nd[d] = md[d]; ns[d] = ms[d]; np[d] = mp[d];
    if (can && g >= 0) begin
      nv[d] = 1'b1; nd[d] = data[g*8 +: 8]; ns[d] = g; np[d] = (g + 1) % n;
    end
  endtask

  task automatic step();
    #1;
    model(0, 4, in_valid_a, in_data_a, out_ready_a, in_ready_a, out_valid_a, out_data_a, out_sel_a);
    model(1, 3, {1'b0, in_valid_b}, {8'h00, in_data_b}, out_ready_b, {1'b0, in_ready_b},
          out_valid_b, out_data_b, out_sel_b);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      mv[d] = nv[d]; md[d] = nd[d]; ms[d] = ns[d]; mp[d] = np[d];
    end
    @(negedge clk);
  endtask

  initial begin
    in_valid_a = 4'hF; in_data_a = 32'h0; out_ready_a = 1'b1;
    in_valid_b = 3'h7; in_data_b = 24'h0; out_ready_b = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready_a", in_ready_a, 0);
    check("rst_in_ready_b", in_ready_b, 0);
    check("rst_out_valid_a", out_valid_a, 0);
    check("rst_out_data_a", out_data_a, 0);
    check("rst_out_sel_a", out_sel_a, 0);
    rst_n = 1'b1;
    // single channel
    in_valid_a = 4'b0100; in_data_a = {8'h44, 8'hA5, 8'h22, 8'h11}; in_valid_b = 3'b000;
    step();
    in_valid_a = 4'b0000;
    check("single_valid", out_valid_a, 1);
    check("single_data", out_data_a, 8'hA5);
    check("single_sel", out_sel_a, 2);
    // backpressure
    out_ready_a = 1'b0; in_valid_a = 4'b0010; in_data_a = {8'h44, 8'h33, 8'h5A, 8'h11};
    repeat (3) begin
      step();
      check("bp_in_ready", in_ready_a, 0);
      check("bp_data_stable", out_data_a, 8'hA5);
    end
    out_ready_a = 1'b1;
    #1 check("bp_release_ready", in_ready_a, 4'b0010);
    step();
    check("bp_load_sel", out_sel_a, 1);
    check("bp_load_data", out_data_a, 8'h5A);
    // wrap: ch2 alone moves ptr to 3, then ch0/ch3 contend
    in_valid_a = 4'b0100;
    step();
    in_valid_a = 4'b1001; in_data_a = {8'hD3, 8'h22, 8'h11, 8'hD0};
    step();
    check("wrap_first", out_sel_a, FIXED ? 0 : 3);
    step();
    check("wrap_second", out_sel_a, 0);
    in_valid_a = 4'hF;
    step();
    check("wrap_ptr", out_sel_a, FIXED ? 0 : 1);
    // fairness on both widths of channel count
    rst_n = 1'b0; model_reset();
    @(negedge clk) rst_n = 1'b1;
    in_valid_a = 4'hF; in_data_a = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid_b = 3'h7; in_data_b = {8'h22, 8'h21, 8'h20};
    for (int k = 0; k < 6; k++) begin
      step();
      check("fair_sel_n4", out_sel_a, FIXED ? 0 : k % 4);
      check("fair_sel_n3", out_sel_b, FIXED ? 0 : k % 3);
      check("fair_data_n3", out_data_b, FIXED ? 8'h20 : 8'h20 + k % 3);
    end
    // asynchronous reset mid-transfer
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid_a, 0);
    check("arst_out_data", out_data_a, 0);
    check("arst_out_sel", out_sel_a, 0);
    check("arst_in_ready", in_ready_a, 0);
    check("arst_out_valid_n3", out_valid_b, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    // random traffic
    repeat (400) begin
      in_valid_a = 4'($urandom); in_data_a = $urandom; out_ready_a = ($urandom % 4) != 0;
      in_valid_b = 3'($urandom); in_data_b = 24'($urandom); out_ready_b = ($urandom % 4) != 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
